bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Round-robin arbiter and master-side multiplexer for the shared system bus. It receives the CPU's instruction-fetch master (M0) and memory-stage master (M1), plus up to two further masters such as DMA or debug, on ports M0..M3. It grants exactly one master at a time and routes that master's address/strobe/write signals onto the single shared bus. Read data is broadcast to all masters; Rdy_ is returned only to the current owner.

Parameters:
NUM_MASTERS, 4, number of bus masters; must be a power of two, 2..8
OWNER_W, 2, owner index width; must equal log2(NUM_MASTERS)
ADDR_W, 30, word address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock, all state on rising edge
reset_  in  1  synchronous active-low reset (sampled on rising clk edge)
MReq_  in  NUM_MASTERS  per-master bus request, active-low
MGrnt_  out  NUM_MASTERS  per-master grant, active-low, registered, one-hot-low
MAddr  in  NUM_MASTERS*ADDR_W  flattened master addresses; master i at bits [i*ADDR_W +: ADDR_W]
MAs_  in  NUM_MASTERS  per-master address strobe, active-low
MRW  in  NUM_MASTERS  per-master read(1)/write(0)
MWrData  in  NUM_MASTERS*DATA_W  flattened master write data
MRdData  out  DATA_W  shared read data broadcast to all masters
MRdy_  out  NUM_MASTERS  per-master ready, active-low
SRdData  in  DATA_W  read data from the slave side
SRdy_  in  1  ready from the slave side, active-low
SAddr  out  ADDR_W  shared bus address
SAs_  out  1  shared address strobe, active-low
SRW  out  1  shared read/write
SWrData  out  DATA_W  shared write data
Owner  out  OWNER_W  registered index of the granted master

Behaviour:
- State: Owner register (OWNER_W bits) and MGrnt_ register. MGrnt_[i]=0 iff Owner==i at all times.
- Reset (reset_=0 at rising edge): Owner=0, MGrnt_ = all ones except bit 0 = 0. The grant parks on master 0. Reset takes priority over any arbitration in the same cycle, including mid-transfer. No in-flight transfer state is retained.
- Arbitration is evaluated every rising edge with reset_=1:
  - MReq_[Owner]==0: Owner holds. No preemption, even if other masters are waiting.
  - MReq_[Owner]==1: search i = Owner+1, Owner+2, … Owner+NUM_MASTERS-1 modulo NUM_MASTERS. The first index with MReq_[i]==0 becomes the new Owner.
  - If no master requests, Owner is unchanged (grant parks on the last owner).
- Grant latency: a request from a non-owner, sampled at edge t while the owner is released, yields MGrnt_ low and Owner updated immediately after edge t (visible in cycle t+1). A master requesting while already parked-owner is granted with 0 cycles of wait.
- Handover is one cycle. An owner that deasserts MReq_ in cycle t loses the grant after edge t if any other master requests. It keeps the grant otherwise.
- Round-robin wrap: index arithmetic is modulo NUM_MASTERS. From Owner=NUM_MASTERS-1, the search starts at 0.
- Shared outputs are combinational from the Owner register:
  - SAddr = MAddr[Owner], SAs_ = MAs_[Owner], SRW = MRW[Owner], SWrData = MWrData[Owner].
  - After reset they reflect master 0's inputs.
- Return path is combinational:
  - MRdData = SRdData for all masters.
  - MRdy_[i] = SRdy_ when Owner==i, else 1.
  - Non-owners never see ready.
- Masters issue MAs_ only while granted. The arbiter does not gate SAs_ on MReq_.
- No combinational path from MReq_ to MGrnt_ or Owner.

Test Plan:
- Reset: hold reset_=0 for 2 cycles with MReq_=4'b0000 -> Owner=0, MGrnt_=4'b1110. SAddr follows MAddr[0]. Then reset_=1 with M0 requesting -> Owner stays 0.
- Round-robin: Owner=0, all four request; M0 releases at edge t -> Owner=1 at t+1. Then M1 releases -> 2, M2 releases -> 3, M3 releases -> 0 (wrap). MGrnt_ sequence is 1101, 1011, 0111, 1110.
- No preemption: Owner=1 holds MReq_[1]=0 for 10 cycles while M2 and M3 request -> MGrnt_=4'b1101 for all 10 cycles. M1 releases -> Owner=2 next cycle.
- Parking: Owner=2 releases with no other requests -> Owner stays 2, MGrnt_=4'b1011. M0 requests later -> granted the cycle after it is sampled.
- Mux/ready routing: Owner=3, MAddr[3]=30'h0000_1234, MRW[3]=0, MWrData[3]=32'hDEAD_BEEF, SRdy_=0 -> SAddr=30'h0000_1234, SRW=0, SWrData=32'hDEAD_BEEF, MRdy_=4'b0111.
- Reset mid-operation: Owner=2 with SAs_ low, reset_=0 for one edge -> Owner=0, MGrnt_=4'b1110 the next cycle, regardless of requests.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Shared system bus bundle between the bus masters, the arbiter and the slave side.
// The arbiter uses the "slave" modport (it sits below the masters); the "master"
// modport is the opposite view, used by whatever drives the masters and the slave.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        MReq_;
    logic [NUM_MASTERS-1:0]        MGrnt_;
    logic [NUM_MASTERS*ADDR_W-1:0] MAddr;
    logic [NUM_MASTERS-1:0]        MAs_;
    logic [NUM_MASTERS-1:0]        MRW;
    logic [NUM_MASTERS*DATA_W-1:0] MWrData;
    logic [DATA_W-1:0]             MRdData;
    logic [NUM_MASTERS-1:0]        MRdy_;
    logic [DATA_W-1:0]             SRdData;
    logic                          SRdy_;
    logic [ADDR_W-1:0]             SAddr;
    logic                          SAs_;
    logic                          SRW;
    logic [DATA_W-1:0]             SWrData;

    modport slave (
        input  MReq_, MAddr, MAs_, MRW, MWrData, SRdData, SRdy_,
        output MGrnt_, MRdData, MRdy_, SAddr, SAs_, SRW, SWrData
    );

    modport master (
        output MReq_, MAddr, MAs_, MRW, MWrData, SRdData, SRdy_,
        input  MGrnt_, MRdData, MRdy_, SAddr, SAs_, SRW, SWrData
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and master-side multiplexer for the shared system bus.
// The owner holds the bus as long as it requests; once it releases, the next
// requesting master after it (modulo NUM_MASTERS) takes over on the next edge.
// With no requests the grant parks on the last owner.
module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32
) (
    input  logic               clk,
    input  logic               reset_,
    bus_arbiter_if.slave       bus,
    output logic [OWNER_W-1:0] Owner
);
    localparam logic [NUM_MASTERS-1:0] oneHot0 = NUM_MASTERS'(1);

    logic [OWNER_W-1:0]     ownerQ;
    logic [NUM_MASTERS-1:0] grantQ;
    logic [OWNER_W-1:0]     nextOwner;
    logic [OWNER_W-1:0]     cand;
    logic                   found;
    logic [NUM_MASTERS-1:0] rdy;

    // Next owner: hold while the owner requests, else first requester after it.
    // Index wrap comes for free from the OWNER_W-bit addition (power-of-two count).
    always_comb begin
        nextOwner = ownerQ;
        cand      = '0;
        found     = 1'b0;
        if (bus.MReq_[ownerQ]) begin
            for (int k = 1; k < NUM_MASTERS; k++) begin
                cand = ownerQ + OWNER_W'(k);
                if (!found && !bus.MReq_[cand]) begin
                    nextOwner = cand;
                    found     = 1'b1;
                end
            end
        end
    end

    // Owner and grant registers; grant is decoded from the same next value so
    // MGrnt_ and Owner can never disagree.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            ownerQ <= '0;
            grantQ <= ~oneHot0;
        end else begin
            ownerQ <= nextOwner;
            grantQ <= ~(oneHot0 << nextOwner);
        end
    end

    // Ready goes back to the owner only; everyone else sees not-ready.
    always_comb begin
        rdy         = '1;
        rdy[ownerQ] = bus.SRdy_;
    end

    assign Owner       = ownerQ;
    assign bus.MGrnt_  = grantQ;
    assign bus.MRdy_   = rdy;
    assign bus.MRdData = bus.SRdData;
    assign bus.SAddr   = bus.MAddr[int'(ownerQ) * ADDR_W +: ADDR_W];
    assign bus.SWrData = bus.MWrData[int'(ownerQ) * DATA_W +: DATA_W];
    assign bus.SAs_    = bus.MAs_[ownerQ];
    assign bus.SRW     = bus.MRW[ownerQ];
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected owner/grant pairs are queued as each
// step is driven and popped for comparison after the clock edge that acts on it.
module tb_bus_arbiter;
    localparam int NM = 4;
    localparam int AW = 30;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       reset_;
    logic [1:0] Owner;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] owner;
        logic [3:0] grant;
    } exp_t;

    exp_t expQ[$];

    bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_arbiter #(.NUM_MASTERS(NM), .OWNER_W(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus),
        .Owner  (Owner)
    );

    always #5 clk = ~clk;

    task automatic pushExp(input string tag, input logic [1:0] o);
        exp_t e;
        e.tag   = tag;
        e.owner = o;
        e.grant = ~(4'b0001 << o);
        expQ.push_back(e);
    endtask

    task automatic popCheck();
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed owner=%0d", Owner);
        end else begin
            e = expQ.pop_front();
            assert (Owner === e.owner && bus.MGrnt_ === e.grant) else begin
                errors++;
                $error("FAIL %s observed owner=%0d grant=%b expected owner=%0d grant=%b",
                       e.tag, Owner, bus.MGrnt_, e.owner, e.grant);
            end
        end
    endtask

    // Drive request pattern, queue the expectation, clock once, then compare.
    task automatic step(input string tag, input logic [3:0] req, input logic [1:0] expOwner);
        bus.MReq_ = req;
        pushExp(tag, expOwner);
        @(posedge clk);
        #2;
        popCheck();
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    initial begin
        reset_      = 1'b0;
        bus.MReq_   = 4'b0000;
        bus.MAs_    = 4'b1111;
        bus.MRW     = 4'b1111;
        bus.SRdy_   = 1'b1;
        bus.SRdData = 32'hCAFE_0001;
        for (int i = 0; i < NM; i++) begin
            bus.MAddr[i*AW +: AW]   = 30'h100 + 30'(i);
            bus.MWrData[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        end

        // Reset held two edges with every master requesting
        step("reset_edge1", 4'b0000, 2'd0);
        step("reset_edge2", 4'b0000, 2'd0);
        checkVal("reset_saddr", 32'(bus.SAddr), 32'h100);
        checkVal("reset_swrdata", bus.SWrData, 32'hA000_0000);

        reset_ = 1'b1;
        step("m0_holds_after_reset", 4'b1110, 2'd0);
        step("all_req_no_preempt", 4'b0000, 2'd0);

        // Round robin around the ring
        step("rr_0_to_1", 4'b0001, 2'd1);
        step("rr_1_to_2", 4'b0011, 2'd2);
        step("rr_2_to_3", 4'b0111, 2'd3);
        step("rr_wrap_3_to_0", 4'b1000, 2'd0);

        // Owner 1 holds for 10 cycles while M2/M3 wait
        step("to_owner1", 4'b0001, 2'd1);
        for (int i = 0; i < 10; i++) step("no_preempt_hold", 4'b0001, 2'd1);
        step("m1_release_to_2", 4'b0011, 2'd2);

        // Parking on owner 2, then M0 gets it one edge after asking
        step("park_2_a", 4'b1111, 2'd2);
        step("park_2_b", 4'b1111, 2'd2);
        step("park_then_m0", 4'b1110, 2'd0);

        // Skip over idle masters straight to M3
        step("park_0", 4'b1111, 2'd0);
        step("skip_to_3", 4'b0111, 2'd3);

        // Mux and ready routing with owner 3
        bus.MAddr[3*AW +: AW]   = 30'h0000_1234;
        bus.MRW                 = 4'b0111;
        bus.MWrData[3*DW +: DW] = 32'hDEAD_BEEF;
        bus.MAs_                = 4'b0111;
        bus.SRdy_               = 1'b0;
        bus.SRdData             = 32'h5555_AAAA;
        #1;
        checkVal("mux_saddr", 32'(bus.SAddr), 32'h0000_1234);
        checkVal("mux_srw", 32'(bus.SRW), 32'h0);
        checkVal("mux_swrdata", bus.SWrData, 32'hDEAD_BEEF);
        checkVal("mux_sas", 32'(bus.SAs_), 32'h0);
        checkVal("rdy_owner3", 32'(bus.MRdy_), 32'h7);
        checkVal("rddata_bcast", bus.MRdData, 32'h5555_AAAA);
        bus.SRdy_ = 1'b1;
        #1;
        checkVal("rdy_none", 32'(bus.MRdy_), 32'hF);
        bus.MAs_ = 4'b1111;
        bus.MRW  = 4'b1111;

        // Wrap from 3 skipping M0 (not requesting) to M1
        step("wrap_3_to_1", 4'b1101, 2'd1);
        bus.SRdy_ = 1'b0;
        #1;
        checkVal("rdy_owner1", 32'(bus.MRdy_), 32'hD);
        bus.SRdy_ = 1'b1;

        // Reset in the middle of a transfer by owner 2
        step("to_owner2", 4'b1011, 2'd2);
        bus.MAs_ = 4'b1011;
        #1;
        checkVal("mid_sas_low", 32'(bus.SAs_), 32'h0);
        checkVal("mid_saddr", 32'(bus.SAddr), 32'h102);
        reset_ = 1'b0;
        step("reset_mid_op", 4'b1011, 2'd0);
        checkVal("post_reset_saddr", 32'(bus.SAddr), 32'h100);
        reset_ = 1'b1;
        step("after_reset_to_2", 4'b1011, 2'd2);

        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
